data_mem_unit: RTL and testbench

- Data-memory responder at the MEM stage of the pipelined CPU. It is the other end of the memRd/memWt/Load/Store interface that the control unit drives.
- Performs byte, halfword and word loads and stores on an internal word-organised RAM, with byte-lane selection and sign/zero extension.
- Inserts a configurable number of wait states and holds the pipeline with a stall output until each access completes.

---
 rtl/data_mem_unit_if.sv | 23 ++
 rtl/data_mem_unit.sv | 148 ++++++++++++++
 tb/tb_data_mem_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// MEM-stage bus between the control unit (master) and the data-memory responder (slave).
interface data_mem_unit_if;
  logic        memRd;
  logic        memWt;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misalign;

  modport master (
    output memRd, memWt, Load, Store, addr, wdata,
    input  rdata, done, stall, misalign
  );

  modport slave (
    input  memRd, memWt, Load, Store, addr, wdata,
    output rdata, done, stall, misalign
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory responder: byte/half/word loads and stores on a word RAM, with
// programmable wait states and a pipeline stall held until each access completes.
module data_mem_unit #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  data_mem_unit_if.slave bus
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [1:0]            lane_q;
  logic [31:0]           wdata_q;
  logic [2:0]            load_q;
  logic [1:0]            store_q;
  logic                  is_store_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic        req, aligned, accept, access;
  logic [31:0] rd_word, shifted, load_res, wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];
  assign req = bus.memRd | bus.memWt;

  // Alignment is judged on the operation that will actually run: the store wins a tie.
  always_comb begin
    aligned = 1'b1;
    if (bus.memWt) begin
      case (bus.Store)
        2'b00:   aligned = 1'b1;
        2'b01:   aligned = ~bus.addr[0];
        default: aligned = (bus.addr[1:0] == 2'b00);
      endcase
    end else begin
      case (bus.Load)
        3'b000, 3'b001: aligned = 1'b1;
        3'b010, 3'b011: aligned = ~bus.addr[0];
        default:        aligned = (bus.addr[1:0] == 2'b00);
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.stall    = 1'b0;
    bus.done     = 1'b0;
    bus.misalign = 1'b0;
    accept       = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (req && aligned) begin
            bus.stall = 1'b1;
            accept    = 1'b1;
            state_nxt = BUSY;
          end else if (req) begin
            bus.misalign = 1'b1;
          end
        end
        BUSY: begin
          bus.stall = 1'b1;
          if (cnt == 4'd0) state_nxt = DONE;
        end
        DONE: begin
          bus.done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign access = rst && (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= WAIT_INIT;
        widx_q     <= bus.addr[ADDR_WIDTH+1:2];
        lane_q     <= bus.addr[1:0];
        wdata_q    <= bus.wdata;
        load_q     <= bus.Load;
        store_q    <= bus.Store;
        is_store_q <= bus.memWt;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !is_store_q) bus.rdata <= load_res;
    end
  end

  assign rd_word  = mem[widx_q];
  assign shifted  = rd_word >> {lane_q, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (load_q)
      3'b000:  load_res = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_res = {24'h0, byte_sel};
      3'b010:  load_res = {{16{half_sel[15]}}, half_sel};
      3'b011:  load_res = {16'h0, half_sel};
      default: load_res = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (store_q)
      2'b00: begin
        wdata_rep = {4{wdata_q[7:0]}};
        be        = 4'b0001 << lane_q;
      end
      2'b01: begin
        wdata_rep = {2{wdata_q[15:0]}};
        be        = lane_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = wdata_q;
        be        = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && is_store_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx_q][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: two instances (2 and 0 wait states).
module tb_data_mem_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s [2];
  logic        rd_s  [2];
  logic        wt_s  [2];
  logic [2:0]  ld_s  [2];
  logic [1:0]  st_s  [2];
  logic [31:0] a_s   [2];
  logic [31:0] wd_s  [2];
  logic [31:0] rdata_o [2];
  logic        done_o  [2];
  logic        stall_o [2];
  logic        mis_o   [2];

  data_mem_unit_if bus0 ();
  data_mem_unit_if bus1 ();

  assign bus0.memRd = rd_s[0];
  assign bus0.memWt = wt_s[0];
  assign bus0.Load  = ld_s[0];
  assign bus0.Store = st_s[0];
  assign bus0.addr  = a_s[0];
  assign bus0.wdata = wd_s[0];
  assign bus1.memRd = rd_s[1];
  assign bus1.memWt = wt_s[1];
  assign bus1.Load  = ld_s[1];
  assign bus1.Store = st_s[1];
  assign bus1.addr  = a_s[1];
  assign bus1.wdata = wd_s[1];
  assign rdata_o[0] = bus0.rdata;
  assign done_o[0]  = bus0.done;
  assign stall_o[0] = bus0.stall;
  assign mis_o[0]   = bus0.misalign;
  assign rdata_o[1] = bus1.rdata;
  assign done_o[1]  = bus1.done;
  assign stall_o[1] = bus1.stall;
  assign mis_o[1]   = bus1.misalign;

  data_mem_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst_s[0]), .bus(bus0));
  data_mem_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst_s[1]), .bus(bus1));

  typedef struct {
    bit          mis;
    logic [31:0] rdata;
    int unsigned stall;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned scnt [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: pops an expectation whenever a DUT completes or faults an access.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_s[g]) begin
        scnt[g] = 0;
      end else begin
        if (stall_o[g]) scnt[g]++;
        if (done_o[g] || mis_o[g]) begin
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            total++;
            $display("FAIL unexpected_event dut%0d: done=%b misalign=%b with nothing pending",
                     g, done_o[g], mis_o[g]);
          end else begin
            exp_t e;
            if (g == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.mis) begin
              check($sformatf("dut%0d misalign_flag", g), {31'h0, mis_o[g]}, 32'h1);
              check($sformatf("dut%0d misalign_stall", g), {31'h0, stall_o[g]}, 32'h0);
              check($sformatf("dut%0d misalign_done", g), {31'h0, done_o[g]}, 32'h0);
              check($sformatf("dut%0d misalign_rdata", g), rdata_o[g], e.rdata);
            end else begin
              check($sformatf("dut%0d rdata", g), rdata_o[g], e.rdata);
              check($sformatf("dut%0d stall_len", g), scnt[g], e.stall);
            end
          end
          scnt[g] = 0;
        end
      end
    end
  end

  task automatic idle_bus(input int sel);
    rd_s[sel] = 1'b0;
    wt_s[sel] = 1'b0;
    ld_s[sel] = 3'b100;
    st_s[sel] = 2'b10;
    a_s[sel]  = '0;
    wd_s[sel] = '0;
  endtask

  task automatic access(input int sel, input logic rd, input logic wt, input logic [2:0] ld,
                        input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd,
                        input bit mis, input logic [31:0] exp_rdata, input int unsigned exp_stall);
    exp_t e;
    bit seen = 1'b0;
    e.mis = mis; e.rdata = exp_rdata; e.stall = exp_stall;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
    @(posedge clk); #1;
    rd_s[sel] = rd; wt_s[sel] = wt; ld_s[sel] = ld; st_s[sel] = st;
    a_s[sel] = a; wd_s[sel] = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o[sel] || mis_o[sel]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL timeout dut%0d addr=0x%08h: no done/misalign within 40 cycles", sel, a);
    end
    @(posedge clk); #1;
    idle_bus(sel);
  endtask

  task automatic load(input int sel, input logic [2:0] ld, input logic [31:0] a,
                      input logic [31:0] exp_rdata, input int unsigned exp_stall);
    access(sel, 1'b1, 1'b0, ld, 2'b10, a, 32'h0, 1'b0, exp_rdata, exp_stall);
  endtask

  task automatic store(input int sel, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] prev_rdata, input int unsigned exp_stall);
    access(sel, 1'b0, 1'b1, 3'b100, st, a, wd, 1'b0, prev_rdata, exp_stall);
  endtask

  initial begin
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    idle_bus(0);
    idle_bus(1);
    // A misaligned request held during reset must not raise misalign or stall.
    rd_s[0] = 1'b1; a_s[0] = 32'h22;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rdata_o[0], 32'h0);
    check("reset_stall", {31'h0, stall_o[0]}, 32'h0);
    check("reset_done", {31'h0, done_o[0]}, 32'h0);
    check("reset_misalign", {31'h0, mis_o[0]}, 32'h0);
    check("reset_rdata_w0", rdata_o[1], 32'h0);
    @(posedge clk); #1;
    idle_bus(0);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;

    store(0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 4);
    load (0, 3'b100, 32'h10, 32'hDEADBEEF, 4);
    load (0, 3'b000, 32'h13, 32'hFFFFFFDE, 4);
    load (0, 3'b001, 32'h13, 32'h000000DE, 4);
    load (0, 3'b010, 32'h12, 32'hFFFFDEAD, 4);
    load (0, 3'b011, 32'h10, 32'h0000BEEF, 4);

    store(0, 2'b00, 32'h11, 32'h12345677, 32'h0000BEEF, 4);
    load (0, 3'b100, 32'h10, 32'hDEAD77EF, 4);
    store(0, 2'b01, 32'h12, 32'h0000A5A5, 32'hDEAD77EF, 4);
    load (0, 3'b100, 32'h10, 32'hA5A577EF, 4);

    store(0, 2'b10, 32'h20, 32'h13572468, 32'hA5A577EF, 4);
    access(0, 1'b1, 1'b0, 3'b100, 2'b10, 32'h22, 32'h0, 1'b1, 32'hA5A577EF, 0);
    access(0, 1'b0, 1'b1, 3'b100, 2'b01, 32'h23, 32'h0000FFFF, 1'b1, 32'hA5A577EF, 0);
    load (0, 3'b100, 32'h20, 32'h13572468, 4);

    access(0, 1'b1, 1'b1, 3'b100, 2'b10, 32'h30, 32'h11112222, 1'b0, 32'h13572468, 4);
    load (0, 3'b100, 32'h30, 32'h11112222, 4);

    store(0, 2'b11, 32'h50, 32'h01020304, 32'h11112222, 4);
    load (0, 3'b000, 32'h52, 32'h00000002, 4);
    load (0, 3'b111, 32'h50, 32'h01020304, 4);

    store(0, 2'b10, 32'h40, 32'h00000000, 32'h01020304, 4);
    @(posedge clk); #1;
    wt_s[0] = 1'b1; st_s[0] = 2'b10; a_s[0] = 32'h40; wd_s[0] = 32'h55AA55AA;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    idle_bus(0);
    @(posedge clk); #1;
    rst_s[0] = 1'b1;
    @(negedge clk);
    check("abort_stall", {31'h0, stall_o[0]}, 32'h0);
    check("abort_done", {31'h0, done_o[0]}, 32'h0);
    check("abort_rdata", rdata_o[0], 32'h0);
    load (0, 3'b100, 32'h40, 32'h00000000, 4);

    store(0, 2'b10, 32'h1010, 32'hCAFEF00D, 32'h0, 4);
    load (0, 3'b100, 32'h0010, 32'hCAFEF00D, 4);

    store(1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 2);
    load (1, 3'b100, 32'h10, 32'hDEADBEEF, 2);
    load (1, 3'b010, 32'h12, 32'hFFFFDEAD, 2);

    repeat (3) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      $display("FAIL pending_at_end: %0d/%0d expectations left unconsumed, expected 0/0",
               q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
